alu_op_decoder: RTL

- Pipelined decode stage that drives the ALU: it accepts 32-bit MIPS instruction words over a valid/ready handshake and emits registered ALU controls.
- ALU controls emitted: 11-bit one-hot op, shift amount, operand selects, extended immediate, register indices.
- Sits between instruction fetch and the register-read/execute stage.
- Includes a 2-entry skid buffer so that in_ready is a registered signal and a downstream stall never creates a combinational ready path.

---
 rtl/alu_op_decoder.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: pipelined MIPS decode stage that drives the ALU.
//
// Accepts 32-bit instruction words over a valid/ready handshake, decodes them
// into registered ALU controls and presents them over a second valid/ready
// handshake. A 2-entry skid buffer (output register + skid register) keeps
// in_ready a registered signal, so a downstream stall never forms a
// combinational ready path from out_ready to in_ready.
//
// Configuration macro: ALU_DECODE_VSHIFT_EN
//   defined   - R-type SLLV/SRLV/SRAV decode to SLL/SRL/SRA with out_sa_from_rs = 1
//   undefined - those functs are illegal and out_sa_from_rs is always 0
//
// Ports:
//   clk, reset           clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready    input handshake (in_ready registered)
//   in_instr, in_tag     instruction word and opaque sequence tag
//   out_valid/out_ready  output handshake
//   out_op               one-hot ALU op (ADD=001h ... SLL=400h)
//   out_sa               shift amount
//   out_sa_from_rs       shift amount comes from rs[4:0]
//   out_rs/rt/rd         register indices (out_rd = write target)
//   out_imm, out_use_imm extended immediate, and b-operand select
//   out_reg_write        result written back
//   out_illegal          unrecognised instruction
//   out_tag              tag of this bundle (RESET_PC_TAG while idle after reset)

module alu_op_decoder #(
  parameter logic [7:0] RESET_PC_TAG = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [7:0]  in_tag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] out_op,
  output logic [4:0]  out_sa,
  output logic        out_sa_from_rs,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic        out_use_imm,
  output logic        out_reg_write,
  output logic        out_illegal,
  output logic [7:0]  out_tag
);

  localparam logic [10:0] OpAdd  = 11'h001;
  localparam logic [10:0] OpAnd  = 11'h002;
  localparam logic [10:0] OpXor  = 11'h004;
  localparam logic [10:0] OpOr   = 11'h008;
  localparam logic [10:0] OpNor  = 11'h010;
  localparam logic [10:0] OpSub  = 11'h020;
  localparam logic [10:0] OpSltu = 11'h040;
  localparam logic [10:0] OpSlt  = 11'h080;
  localparam logic [10:0] OpSra  = 11'h100;
  localparam logic [10:0] OpSrl  = 11'h200;
  localparam logic [10:0] OpSll  = 11'h400;

  typedef struct packed {
    logic [10:0] op;
    logic [4:0]  sa;
    logic        sa_from_rs;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        illegal;
    logic [7:0]  tag;
  } bundle_t;

  bundle_t dec;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    in_ready_q;
  logic    in_fire;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       legal;
  logic       store;

  assign opcode  = in_instr[31:26];
  assign funct   = in_instr[5:0];
  assign in_fire = in_valid & in_ready_q;

  // Combinational decode of the incoming word.
  always_comb begin
    dec     = '0;
    legal   = 1'b1;
    store   = 1'b0;
    dec.rs  = in_instr[25:21];
    dec.rt  = in_instr[20:16];
    dec.tag = in_tag;
    if (opcode == 6'h00) begin
      dec.rd = in_instr[15:11];
      case (funct)
        6'h00: begin dec.op = OpSll; dec.sa = in_instr[10:6]; end
        6'h02: begin dec.op = OpSrl; dec.sa = in_instr[10:6]; end
        6'h03: begin dec.op = OpSra; dec.sa = in_instr[10:6]; end
`ifdef ALU_DECODE_VSHIFT_EN
        6'h04: begin dec.op = OpSll; dec.sa_from_rs = 1'b1; end
        6'h06: begin dec.op = OpSrl; dec.sa_from_rs = 1'b1; end
        6'h07: begin dec.op = OpSra; dec.sa_from_rs = 1'b1; end
`endif
        6'h20, 6'h21: dec.op = OpAdd;
        6'h22, 6'h23: dec.op = OpSub;
        6'h24:        dec.op = OpAnd;
        6'h25:        dec.op = OpOr;
        6'h26:        dec.op = OpXor;
        6'h27:        dec.op = OpNor;
        6'h2a:        dec.op = OpSlt;
        6'h2b:        dec.op = OpSltu;
        default:      legal  = 1'b0;
      endcase
    end else begin
      dec.rd      = in_instr[20:16];
      dec.use_imm = 1'b1;
      dec.imm     = {{16{in_instr[15]}}, in_instr[15:0]};
      case (opcode)
        6'h08, 6'h09: dec.op = OpAdd;
        6'h0a:        dec.op = OpSlt;
        6'h0b:        dec.op = OpSltu;
        6'h0c: begin dec.op = OpAnd; dec.imm = {16'h0000, in_instr[15:0]}; end
        6'h0d: begin dec.op = OpOr;  dec.imm = {16'h0000, in_instr[15:0]}; end
        6'h0e: begin dec.op = OpXor; dec.imm = {16'h0000, in_instr[15:0]}; end
        // LUI: execute shifts the zero-extended imm (b operand) left by 16.
        6'h0f: begin
          dec.op  = OpSll;
          dec.sa  = 5'd16;
          dec.imm = {16'h0000, in_instr[15:0]};
        end
        6'h23:        dec.op = OpAdd;
        6'h2b: begin dec.op = OpAdd; store = 1'b1; end
        default:      legal  = 1'b0;
      endcase
    end
    if (!legal) begin
      dec.op         = '0;
      dec.sa         = '0;
      dec.sa_from_rs = 1'b0;
      dec.imm        = '0;
      dec.use_imm    = 1'b0;
    end
    dec.illegal   = ~legal;
    // Writes to $0 are suppressed, which makes the all-zero word a NOP.
    dec.reg_write = legal & ~store & (dec.rd != 5'd0);
  end

  // Skid buffer next state. in_ready is only high while the skid is empty,
  // so an input transfer never coincides with a skid drain.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      out_q.tag    <= RESET_PC_TAG;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_op         = out_q.op;
  assign out_sa         = out_q.sa;
  assign out_sa_from_rs = out_q.sa_from_rs;
  assign out_rs         = out_q.rs;
  assign out_rt         = out_q.rt;
  assign out_rd         = out_q.rd;
  assign out_imm        = out_q.imm;
  assign out_use_imm    = out_q.use_imm;
  assign out_reg_write  = out_q.reg_write;
  assign out_illegal    = out_q.illegal;
  assign out_tag        = out_q.tag;

endmodule
